// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes, M/W bubble, EX forwarding, ecall drain/halt.
// Build option: define PIPE_FWD_EN to enable EX operand forwarding; otherwise every RAW dependence stalls in ID.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_ADDR_W-1:0]  ex_rs1,
  input  logic [REG_ADDR_W-1:0]  ex_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_wb_en,
  input  logic                   ex_is_load,
  input  logic                   ex_branch_taken,
  input  logic                   ex_ecall,
  input  logic [REG_ADDR_W-1:0]  mem_rd,
  input  logic                   mem_wb_en,
  input  logic                   dm_req,
  input  logic                   dm_ready,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic                   wb_en,
  input  logic                   wb_ecall,
  input  logic                   resume,
  output logic                   pc_stall,
  output logic                   fd_stall,
  output logic                   fd_flush,
  output logic                   de_stall,
  output logic                   de_flush,
  output logic                   em_stall,
  output logic                   mw_bubble,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             drain_q, drain_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       ex_writes, mem_writes, wb_writes;
  logic       load_use, data_hazard, mem_wait;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  function automatic logic id_reads(input logic [REG_ADDR_W-1:0] rd);
    return (id_rs1_used && (id_rs1 == rd)) || (id_rs2_used && (id_rs2 == rd));
  endfunction

  assign ex_writes  = ex_wb_en  && (ex_rd  != '0);
  assign mem_writes = mem_wb_en && (mem_rd != '0);
  assign wb_writes  = wb_en     && (wb_rd  != '0);
  assign load_use   = ex_is_load && ex_writes && id_reads(ex_rd);

`ifdef PIPE_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (mem_writes && (mem_rd == rs)) return 2'b01;
    if (wb_writes && (wb_rd == rs))   return 2'b10;
    return 2'b00;
  endfunction

  assign data_hazard = load_use;
  assign fwd_a_raw   = fwd_sel(ex_rs1);
  assign fwd_b_raw   = fwd_sel(ex_rs2);
`else
  logic unused_fwd_srcs;

  // Without forwarding, any in-flight writer of an ID source holds ID until it retires.
  assign data_hazard = load_use
                    || (ex_writes  && id_reads(ex_rd))
                    || (mem_writes && id_reads(mem_rd))
                    || (wb_writes  && id_reads(wb_rd));
  assign fwd_a_raw   = 2'b00;
  assign fwd_b_raw   = 2'b00;
  assign unused_fwd_srcs = ^{ex_rs1, ex_rs2};
`endif

  // Data memory handshake: dm_req is held by M while the access is outstanding; the access
  // completes in the cycle dm_ready=1 (same cycle as dm_req means no wait). Once waiting,
  // only dm_ready is watched since the M stage is frozen.
  always_comb begin
    mem_wait = 1'b0;
    case (state_q)
      S_RUN, S_DRAIN: mem_wait = dm_req && !dm_ready;
      S_MEM_WAIT:     mem_wait = !dm_ready;
      default:        mem_wait = 1'b0;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (mem_wait) begin
          state_d = S_MEM_WAIT;
        end else if (ex_ecall && !ex_branch_taken) begin
          state_d = S_DRAIN;
          drain_d = 2'd2;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // The drain budget only runs while the pipe is actually moving.
        if (!mem_wait) begin
          drain_d = drain_q - 2'd1;
          if (wb_ecall || (drain_q <= 2'd1)) begin
            state_d = S_HALTED;
            drain_d = '0;
          end
        end
      end
      S_HALTED: begin
        if (resume) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_flush  = 1'b0;
    de_stall  = 1'b0;
    de_flush  = 1'b0;
    em_stall  = 1'b0;
    mw_bubble = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      if (state_q == S_HALTED) begin
        pc_stall  = 1'b1;
        fd_stall  = 1'b1;
        de_stall  = 1'b1;
        em_stall  = 1'b1;
        mw_bubble = 1'b1;
        halted    = 1'b1;
      end else if (mem_wait) begin
        pc_stall  = 1'b1;
        fd_stall  = 1'b1;
        de_stall  = 1'b1;
        em_stall  = 1'b1;
        mw_bubble = 1'b1;
      end else if (state_q == S_DRAIN) begin
        pc_stall = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
      end else if (ex_branch_taken) begin
        fd_flush = 1'b1;
        de_flush = 1'b1;
      end else if (data_hazard) begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_flush = 1'b1;
      end
    end
  end

  assign stall_cnt_d = (pc_stall && !(&stall_cnt_q))
                     ? stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1}
                     : stall_cnt_q;

  assign fwd_a_sel = rst ? fwd_a_raw : 2'b00;
  assign fwd_b_sel = rst ? fwd_b_raw : 2'b00;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal sequences, then randomized traffic checked against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 16;
  localparam int STALL_MAX = (1 << CW) - 1;

  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_BR   = 8'b0010_1000;
  localparam logic [7:0] C_MW   = 8'b1101_0110;
  localparam logic [7:0] C_DR   = 8'b1010_1000;
  localparam logic [7:0] C_HLT  = 8'b1101_0111;
`ifdef PIPE_FWD_EN
  localparam logic [1:0] FWD_M = 2'b01;
  localparam logic [1:0] FWD_W = 2'b10;
  localparam logic [7:0] HZ_NF = C_IDLE;
`else
  localparam logic [1:0] FWD_M = 2'b00;
  localparam logic [1:0] FWD_W = 2'b00;
  localparam logic [7:0] HZ_NF = C_LU;
`endif

  typedef struct packed {
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2;
    logic          id_rs1_used, id_rs2_used;
    logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          ex_wb_en, ex_is_load, ex_branch_taken, ex_ecall;
    logic [RW-1:0] mem_rd;
    logic          mem_wb_en, dm_req, dm_ready;
    logic [RW-1:0] wb_rd;
    logic          wb_en, wb_ecall, resume;
  } in_t;

  logic          clk;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_rs1_used, id_rs2_used, ex_wb_en, ex_is_load, ex_branch_taken, ex_ecall;
  logic          mem_wb_en, dm_req, dm_ready, wb_en, wb_ecall, resume;
  logic          pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_bubble, halted;
  logic [1:0]    fwd_a_sel, fwd_b_sel, dbg_state;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [12:0] exp_q[$];

  // behavioural model state
  bit m_halted, m_waiting, m_draining;
  int m_drain_left, m_stall;
  bit mw, hz;
  logic [7:0] e_ctrl;
  logic [1:0] e_fa, e_fb;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .ex_ecall(ex_ecall),
    .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .dm_req(dm_req), .dm_ready(dm_ready),
    .wb_rd(wb_rd), .wb_en(wb_en), .wb_ecall(wb_ecall), .resume(resume),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush), .de_stall(de_stall),
    .de_flush(de_flush), .em_stall(em_stall), .mw_bubble(mw_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // driver tasks
  function automatic in_t idle();
    in_t v;
    v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic logic [12:0] lit(input logic [7:0] c, input logic [1:0] fa, input logic [1:0] fb);
    return {1'b1, fa, fb, c};
  endfunction

  task automatic apply(input in_t v);
    rst = v.rst;
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_rs1_used = v.id_rs1_used; id_rs2_used = v.id_rs2_used;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_wb_en = v.ex_wb_en;
    ex_is_load = v.ex_is_load; ex_branch_taken = v.ex_branch_taken; ex_ecall = v.ex_ecall;
    mem_rd = v.mem_rd; mem_wb_en = v.mem_wb_en; dm_req = v.dm_req; dm_ready = v.dm_ready;
    wb_rd = v.wb_rd; wb_en = v.wb_en; wb_ecall = v.wb_ecall; resume = v.resume;
  endtask

  task automatic step(input in_t v, input logic [12:0] l);
    @(posedge clk);
    apply(v);
    exp_q.push_back(l);
  endtask

  task automatic step_c(input in_t v, input logic [7:0] c);
    step(v, lit(c, 2'b00, 2'b00));
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.rst             = ($urandom_range(0, 99) >= 2);
    v.id_rs1          = RW'($urandom_range(0, 7));
    v.id_rs2          = RW'($urandom_range(0, 7));
    v.id_rs1_used     = 1'($urandom_range(0, 1));
    v.id_rs2_used     = 1'($urandom_range(0, 1));
    v.ex_rs1          = RW'($urandom_range(0, 7));
    v.ex_rs2          = RW'($urandom_range(0, 7));
    v.ex_rd           = RW'($urandom_range(0, 7));
    v.ex_wb_en        = 1'($urandom_range(0, 1));
    v.ex_is_load      = 1'($urandom_range(0, 1));
    v.ex_branch_taken = ($urandom_range(0, 99) < 12);
    v.ex_ecall        = ($urandom_range(0, 99) < 4);
    v.mem_rd          = RW'($urandom_range(0, 7));
    v.mem_wb_en       = 1'($urandom_range(0, 1));
    v.dm_req          = ($urandom_range(0, 99) < 25);
    v.dm_ready        = ($urandom_range(0, 99) < 55);
    v.wb_rd           = RW'($urandom_range(0, 7));
    v.wb_en           = 1'($urandom_range(0, 1));
    v.wb_ecall        = ($urandom_range(0, 99) < 10);
    v.resume          = ($urandom_range(0, 99) < 30);
    return v;
  endfunction

  // model helpers
  function automatic bit id_needs(input logic [RW-1:0] r);
    return (r != 0) && ((id_rs1_used && id_rs1 == r) || (id_rs2_used && id_rs2 == r));
  endfunction

  function automatic logic [1:0] model_fwd(input logic [RW-1:0] rs);
    logic [1:0] s;
    s = 2'b00;
`ifdef PIPE_FWD_EN
    if (wb_en && wb_rd != 0 && wb_rd == rs) s = 2'b10;
    if (mem_wb_en && mem_rd != 0 && mem_rd == rs) s = 2'b01;
`else
    if (rs == '1) s = 2'b00;
`endif
    return s;
  endfunction

  // scoreboard / compare process: every cycle, mid-way between posedge and the active negedge
  always @(posedge clk) begin
    logic [12:0] l;
    logic pc, fds, fdf, des, def, em, mwb, hl;
    #2;
    {pc, fds, fdf, des, def, em, mwb, hl} = '0;
    e_fa = 2'b00;
    e_fb = 2'b00;
    mw = 1'b0;
    if (!rst) begin
      m_halted = 0; m_waiting = 0; m_draining = 0; m_drain_left = 0; m_stall = 0;
    end else begin
`ifdef PIPE_FWD_EN
      hz = ex_is_load && ex_wb_en && id_needs(ex_rd);
`else
      hz = (ex_wb_en && id_needs(ex_rd)) || (mem_wb_en && id_needs(mem_rd)) || (wb_en && id_needs(wb_rd));
`endif
      if (!m_halted) mw = m_waiting ? !dm_ready : (dm_req && !dm_ready);
      if (m_halted) begin
        pc = 1; fds = 1; des = 1; em = 1; mwb = 1; hl = 1;
      end else if (mw) begin
        pc = 1; fds = 1; des = 1; em = 1; mwb = 1;
      end else if (m_draining) begin
        pc = 1; fdf = 1; def = 1;
      end else if (ex_branch_taken) begin
        fdf = 1; def = 1;
      end else if (hz) begin
        pc = 1; fds = 1; def = 1;
      end
      e_fa = model_fwd(ex_rs1);
      e_fb = model_fwd(ex_rs2);
    end
    e_ctrl = {pc, fds, fdf, des, def, em, mwb, hl};

    check("ctrl", 32'({pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_bubble, halted}), 32'(e_ctrl));
    check("fwd_a", 32'(fwd_a_sel), 32'(e_fa));
    check("fwd_b", 32'(fwd_b_sel), 32'(e_fb));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));

    if (exp_q.size() > 0) begin
      l = exp_q.pop_front();
      if (l[12]) begin
        check("lit_ctrl", 32'({pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_bubble, halted}), 32'(l[7:0]));
        check("lit_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'(l[11:8]));
      end
    end

    if (rst) begin
      if (m_halted) begin
        if (resume) m_halted = 0;
      end else if (m_draining) begin
        if (!mw) begin
          m_drain_left--;
          if (wb_ecall || m_drain_left == 0) begin
            m_draining = 0;
            m_halted = 1;
          end
        end
      end else begin
        m_waiting = mw;
        if (!mw && ex_ecall && !ex_branch_taken) begin
          m_draining = 1;
          m_drain_left = 2;
        end
      end
      if (pc && m_stall < STALL_MAX) m_stall++;
    end
  end

  initial begin
    in_t v;
    v = idle();
    v.rst = 1'b0;
    apply(v);

    // reset
    step_c(v, C_IDLE);
    step_c(v, C_IDLE);
    #3 check("stall_cnt_reset", 32'(stall_cnt), 32'd0);
    step_c(idle(), C_IDLE);

    // three-cycle memory wait, release on the fourth
    v = idle(); v.dm_req = 1;
    repeat (3) step_c(v, C_MW);
    v.dm_ready = 1;
    step_c(v, C_IDLE);
    #3 check("stall_cnt_memwait", 32'(stall_cnt), 32'd3);

    // load-use then forwarding of the load result
    v = idle(); v.ex_is_load = 1; v.ex_wb_en = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_rs1_used = 1;
    step_c(v, C_LU);
    v = idle(); v.mem_rd = 5; v.mem_wb_en = 1; v.ex_rs1 = 5;
    step(v, lit(C_IDLE, FWD_M, 2'b00));
    #3 check("stall_cnt_loaduse", 32'(stall_cnt), 32'd4);
    v = idle(); v.mem_rd = 3; v.mem_wb_en = 1; v.wb_rd = 3; v.wb_en = 1; v.ex_rs2 = 3;
    step(v, lit(C_IDLE, 2'b00, FWD_M));
    v = idle(); v.wb_rd = 7; v.wb_en = 1; v.ex_rs1 = 7;
    step(v, lit(C_IDLE, FWD_W, 2'b00));
    v = idle(); v.wb_rd = 0; v.wb_en = 1; v.ex_rs2 = 0;
    step(v, lit(C_IDLE, 2'b00, 2'b00));

    // ID reads a register still in flight in M (stalls repeatedly without forwarding)
    v = idle(); v.id_rs1 = 3; v.id_rs1_used = 1; v.mem_rd = 3; v.mem_wb_en = 1;
    step_c(v, HZ_NF);
    step_c(v, HZ_NF);

    // taken branch beats load-use
    v = idle(); v.ex_is_load = 1; v.ex_wb_en = 1; v.ex_rd = 5; v.id_rs2 = 5; v.id_rs2_used = 1;
    v.ex_branch_taken = 1;
    step_c(v, C_BR);

    // ecall drain with wb_ecall, halt, resume
    v = idle(); v.ex_ecall = 1;
    step_c(v, C_IDLE);
    step_c(idle(), C_DR);
    v = idle(); v.wb_ecall = 1;
    step_c(v, C_DR);
    step_c(idle(), C_HLT);
    v = idle(); v.resume = 1;
    step_c(v, C_HLT);
    step_c(idle(), C_IDLE);

    // drain counter expiry without wb_ecall
    v = idle(); v.ex_ecall = 1;
    step_c(v, C_IDLE);
    step_c(idle(), C_DR);
    step_c(idle(), C_DR);
    step_c(idle(), C_HLT);
    step_c(idle(), C_HLT);
    v = idle(); v.resume = 1;
    step_c(v, C_HLT);
    step_c(idle(), C_IDLE);

    // memory wait inside DRAIN does not consume drain budget
    v = idle(); v.ex_ecall = 1;
    step_c(v, C_IDLE);
    v = idle(); v.dm_req = 1;
    step_c(v, C_MW);
    step_c(idle(), C_DR);
    step_c(idle(), C_DR);
    step_c(idle(), C_HLT);
    v = idle(); v.resume = 1;
    step_c(v, C_HLT);
    step_c(idle(), C_IDLE);

    // reset mid-DRAIN
    v = idle(); v.ex_ecall = 1;
    step_c(v, C_IDLE);
    step_c(idle(), C_DR);
    v = idle(); v.rst = 0;
    step_c(v, C_IDLE);
    step_c(idle(), C_IDLE);
    step_c(idle(), C_IDLE);

    // reset mid-MEM_WAIT
    v = idle(); v.dm_req = 1;
    step_c(v, C_MW);
    v.rst = 0;
    step_c(v, C_IDLE);
    step_c(idle(), C_IDLE);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(rand_in(), 13'h0);
    end

    @(posedge clk);
    apply(idle());
    @(posedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard/sequencing controller for the 5-stage RISC-V pipeline. Drives stall, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/M and M/W registers. Generates EX-stage operand forwarding selects. Owns the multi-cycle data-memory wait and the ecall drain/halt sequence.

Parameters:
REG_ADDR_W, 5, register index width
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock; all state updates on negedge clk (matches pipeline registers)
rst  in  1  asynchronous, active-low reset
id_rs1, id_rs2  in  REG_ADDR_W  source indices of instruction in ID
id_rs1_used, id_rs2_used  in  1  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  REG_ADDR_W  source indices of instruction in EX
ex_rd  in  REG_ADDR_W  dest of instruction in EX
ex_wb_en, ex_is_load, ex_branch_taken, ex_ecall  in  1  EX-stage controls
mem_rd  in  REG_ADDR_W  dest in M stage (EX/M register output)
mem_wb_en, dm_req, dm_ready  in  1  M-stage writeback enable; data memory request; memory done
wb_rd  in  REG_ADDR_W  dest in WB (M/W register output)
wb_en, wb_ecall  in  1  WB-stage writeback enable; ecall reached WB
resume  in  1  single-cycle pulse leaving HALTED
pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_bubble  out  1  pipeline controls
fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 EX/M alu result, 10 M/W writeback value
halted  out  1  core halted on ecall
stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, drain counter=0, stall_cnt=0. Controls derived from RUN with no hazard, so all outputs 0 and fwd sels 00.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Outputs combinational from state plus inputs. State, drain counter and stall_cnt are registered.
- Priority, highest first: HALTED > memory wait > DRAIN > branch flush > load-use stall.
- Memory wait: dm_req=1 and dm_ready=0, in RUN or DRAIN.
  - Asserts pc_stall, fd_stall, de_stall, em_stall and mw_bubble (M/W loads wb_en=0, ecall=0).
  - From RUN, enter MEM_WAIT. In MEM_WAIT, the same outputs hold until the first cycle with dm_ready=1.
  - That cycle: all stalls drop, mw_bubble=0, return to RUN (or DRAIN if entered from DRAIN).
  - dm_ready=1 in the same cycle as dm_req means zero wait cycles.
- Branch: ex_branch_taken=1 in RUN gives fd_flush=1, de_flush=1 for one cycle, no stall. Any simultaneous load-use is suppressed (wrong path).
- Load-use stall: ex_is_load & ex_wb_en & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Gives pc_stall=1, fd_stall=1, de_flush=1 for exactly one cycle.
- Forwarding, per operand:
  - 01 if mem_wb_en & mem_rd!=0 & mem_rd==ex_rsN.
  - Else 10 if wb_en & wb_rd!=0 & wb_rd==ex_rsN.
  - Else 00. EX/M always wins over M/W.
- Ecall: ex_ecall=1 in RUN (and no branch) enters DRAIN with drain counter=2.
  - In DRAIN: pc_stall=1, fd_flush=1, de_flush=1.
  - Counter decrements on each non-memory-wait cycle.
  - wb_ecall=1 moves to HALTED. If the counter hits 0 without wb_ecall, still go to HALTED.
- HALTED: pc_stall, fd_stall, de_stall, em_stall all 1, mw_bubble=1, halted=1.
  - resume=1 returns to RUN next edge; outputs release that edge. resume outside HALTED is ignored.
- stall_cnt: increments every edge with pc_stall=1 and saturates at all-ones (no wrap).
- Reset mid-MEM_WAIT or mid-DRAIN: immediately RUN, all outputs 0.

Optional Feature:
PIPE_FWD_EN.
- Defined: forwarding as above.
- Undefined: fwd_a_sel/fwd_b_sel tied to 00.
  - Any ID source matching a writing ex_rd, mem_rd or wb_rd (rd!=0) raises the load-use-style stall: pc_stall, fd_stall, de_flush.
  - The stall repeats each cycle until no match remains.
  - Branch and memory-wait priority unchanged.

Test Plan:
- Reset released, no hazards -> all controls 0, fwd 00, stall_cnt=0, halted=0.
- EX lw x5 (ex_rd=5), ID add uses rs1=5 -> one cycle pc_stall=fd_stall=de_flush=1; next cycle mem_rd=5, ex_rs1=5 -> fwd_a_sel=01 (PIPE_FWD_EN).
- mem_rd=3 and wb_rd=3 both writing, ex_rs2=3 -> fwd_b_sel=01; ex_rs2=0 with wb_rd=0 -> 00.
- dm_req=1, dm_ready low 3 cycles -> 3 cycles of pc/fd/de/em stall plus mw_bubble, release on 4th; stall_cnt=3.
- ex_branch_taken=1 together with load-use match -> fd_flush=de_flush=1, pc_stall=0.
- ex_ecall=1 -> DRAIN 2 cycles, wb_ecall -> halted=1 held; resume pulse -> halted=0, stalls released next edge; rst low mid-DRAIN -> immediate RUN.
